// File: rtl/ofifo_drain_ctrl.sv
// Output-FIFO drain sequencer: pops len rows from the PE-array output FIFO into
// consecutive partial-sum SRAM rows, with optional per-column ReLU.
`timescale 1ns/1ps
module ofifo_drain_ctrl #(
  parameter int col    = 8,
  parameter int bw     = 16,
  parameter int addr_w = 11,
  parameter int len_w  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [len_w-1:0]  len,
  input  logic [addr_w-1:0] base_addr,
  input  logic              relu_en,
  input  logic              ofifo_valid,
  input  logic [col*bw-1:0] ofifo_out,
  output logic              ofifo_rd,
  input  logic              mem_gnt,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic [addr_w-1:0] mem_addr,
  output logic [col*bw-1:0] mem_d,
  output logic              busy,
  output logic              done,
  output logic [len_w-1:0]  row_cnt,
  output logic [15:0]       stall_cnt
);
  // state | meaning
  // IDLE  | waiting for start; row_cnt/stall_cnt hold the last drain's results
  // DRAIN | one row per cycle moves whenever the FIFO is valid and the port is granted
  // DONE  | single-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [len_w-1:0]  len_q, len_d;
  logic [addr_w-1:0] base_q, base_d;
  logic              relu_q, relu_d;
  logic [len_w-1:0]  row_cnt_q, row_cnt_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic              fire;
  logic [addr_w-1:0] row_addr;
  logic [col*bw-1:0] relu_row;

  // Transfers are zero-latency from the FIFO head; reset suppresses any pop or write.
  always_comb begin
    fire     = (state_q == DRAIN) && ofifo_valid && mem_gnt && !reset;
    row_addr = base_q + addr_w'(row_cnt_q);
    relu_row = ofifo_out;
    if (relu_q) begin
      for (int i = 0; i < col; i++) begin
        if (ofifo_out[i*bw + bw - 1]) relu_row[i*bw +: bw] = '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    base_d      = base_q;
    relu_d      = relu_q;
    row_cnt_d   = row_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d       = len;
          base_d      = base_addr;
          relu_d      = relu_en;
          row_cnt_d   = '0;
          stall_cnt_d = '0;
          state_d     = (len == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (fire) begin
          row_cnt_d = row_cnt_q + len_w'(1);
          if (row_cnt_q == len_q - len_w'(1)) state_d = DONE;
        end else if (stall_cnt_q != 16'hFFFF) begin
          stall_cnt_d = stall_cnt_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      base_q      <= '0;
      relu_q      <= 1'b0;
      row_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      base_q      <= base_d;
      relu_q      <= relu_d;
      row_cnt_q   <= row_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ofifo_rd  = fire;
  assign mem_cen   = !fire;
  assign mem_wen   = !fire;
  assign mem_addr  = row_addr;
  assign mem_d     = fire ? relu_row : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign row_cnt   = row_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Randomized bench for ofifo_drain_ctrl: a transaction-level drain model plus a
// bench-side FIFO queue, compared against the DUT every cycle, with literal pins.
`timescale 1ns/1ps
module tb_ofifo_drain_ctrl;
  localparam int COL = 8, BW = 16, AW = 11, LW = 12, RW = COL * BW;

  logic          clk = 1'b0;
  logic          reset, start, relu_en, ofifo_valid, ofifo_rd, mem_gnt;
  logic          mem_cen, mem_wen, busy, done;
  logic [LW-1:0] len, row_cnt;
  logic [AW-1:0] base_addr, mem_addr;
  logic [RW-1:0] ofifo_out, mem_d;
  logic [15:0]   stall_cnt;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ofifo_drain_ctrl #(.col(COL), .bw(BW), .addr_w(AW), .len_w(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
    .relu_en(relu_en), .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out),
    .ofifo_rd(ofifo_rd), .mem_gnt(mem_gnt), .mem_cen(mem_cen), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_d(mem_d), .busy(busy), .done(done),
    .row_cnt(row_cnt), .stall_cnt(stall_cnt)
  );

  // model: 0 = idle, 1 = draining, 2 = finishing
  int            m_mode = 0, m_rows = 0, m_len = 0, m_base = 0, m_stall = 0;
  bit            m_relu = 0;
  logic [RW-1:0] fq[$];
  bit            v_en, g_en;
  int            cyc, done_cyc;
  logic [AW-1:0] wr_addr[$];
  logic [RW-1:0] wr_data[$];
  int            wr_cyc[$];

  bit tv [7] = '{1, 1, 0, 1, 0, 1, 1};
  bit tg [7] = '{1, 0, 1, 1, 0, 0, 1};

  function automatic logic [RW-1:0] relu_ref(logic [RW-1:0] r);
    logic [RW-1:0] o;
    o = r;
    for (int i = 0; i < COL; i++)
      if ($signed(r[i*BW +: BW]) < 0) o[i*BW +: BW] = '0;
    return o;
  endfunction

  function automatic logic [RW-1:0] rnd_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string nm, logic [RW-1:0] act, logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    bit            ef;
    logic [RW-1:0] ed;
    logic [AW-1:0] ea;
    mem_gnt     = g_en;
    ofifo_valid = v_en && (fq.size() != 0);
    ofifo_out   = (fq.size() != 0) ? fq[0] : rnd_row();
    #4;
    ef = (m_mode == 1) && ofifo_valid && mem_gnt && !reset;
    ed = ef ? (m_relu ? relu_ref(ofifo_out) : ofifo_out) : '0;
    ea = AW'(m_base + m_rows);
    chk("ofifo_rd", ofifo_rd, ef);
    chk("mem_cen", mem_cen, !ef);
    chk("mem_wen", mem_wen, !ef);
    chk("mem_addr", mem_addr, ea);
    chk("mem_d", mem_d, ed);
    chk("busy", busy, m_mode != 0);
    chk("done", done, m_mode == 2);
    chk("row_cnt", row_cnt, LW'(m_rows));
    chk("stall_cnt", stall_cnt, 16'(m_stall));
    if (mem_cen === 1'b0) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_d);
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc = cyc;
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_rows = 0; m_stall = 0; m_len = 0; m_base = 0; m_relu = 0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_len = len; m_base = base_addr; m_relu = relu_en;
          m_rows = 0; m_stall = 0;
          m_mode = (len == 0) ? 2 : 1;
        end
        1: if (ef) begin
          m_rows++;
          if (m_rows == m_len) m_mode = 2;
        end else if (m_stall < 65535) m_stall++;
        default: m_mode = 0;
      endcase
    end
    if (ef) void'(fq.pop_front());
    #1;
    start = 1'b0;
    cyc++;
  endtask

  task automatic start_drain(int l, int b, bit r);
    len = LW'(l); base_addr = AW'(b); relu_en = r; start = 1'b1;
    cycle();
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (m_mode != 0 && n < budget) begin cycle(); n++; end
    if (m_mode != 0) begin
      checks++; errors++;
      $display("FAIL timeout cyc=%0d actual=busy required=idle", cyc);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc = -1;
  endtask

  initial begin
    logic [RW-1:0] rows [8];
    logic [RW-1:0] rr;
    int s, n, l;
    reset = 1'b1; start = 1'b0; len = '0; base_addr = '0; relu_en = 1'b0;
    v_en = 0; g_en = 0; mem_gnt = 1'b0; ofifo_valid = 1'b0; ofifo_out = '0;
    cyc = 0; done_cyc = -1;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    chk("rst_cen", mem_cen, 1'b1);
    chk("rst_addr", mem_addr, 11'h000);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    cycle();

    // basic drain
    clear_log(); v_en = 1; g_en = 1;
    for (int i = 0; i < 4; i++) begin rows[i] = rnd_row(); fq.push_back(rows[i]); end
    start_drain(4, 'h010, 0);
    wait_idle(20);
    chk("basic_nwr", wr_addr.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      chk("basic_addr", wr_addr[i], 11'h010 + 11'(i));
      chk("basic_data", wr_data[i], rows[i]);
    end
    if (wr_cyc.size() == 4) begin
      chk("basic_consec", wr_cyc[3] - wr_cyc[0], 3);
      chk("basic_done_t", done_cyc, wr_cyc[3] + 1);
    end
    chk("basic_rows", row_cnt, 12'd4);
    chk("basic_stall", stall_cnt, 16'd0);

    // stalls from grant toggling and FIFO valid drop
    clear_log();
    for (int i = 0; i < 3; i++) fq.push_back(rnd_row());
    start_drain(3, 'h020, 0);
    for (int i = 0; i < 7; i++) begin v_en = tv[i]; g_en = tg[i]; cycle(); end
    v_en = 1; g_en = 1;
    wait_idle(10);
    chk("stall_nwr", wr_addr.size(), 3);
    chk("stall_cnt4", stall_cnt, 16'd4);
    chk("stall_rows", row_cnt, 12'd3);

    // ReLU
    clear_log();
    rr = {16'h8000, 16'h00A5, 16'h4000, 16'h0001, 16'h7FFF, 16'h1234, 16'h0007, 16'hFFFB};
    rows[0] = rnd_row();
    fq.push_back(rr); fq.push_back(rows[0]);
    start_drain(2, 'h100, 1);
    wait_idle(10);
    chk("relu_nwr", wr_data.size(), 2);
    if (wr_data.size() == 2) begin
      chk("relu_row0", wr_data[0],
          {16'h0000, 16'h00A5, 16'h4000, 16'h0001, 16'h7FFF, 16'h1234, 16'h0007, 16'h0000});
      chk("relu_row1", wr_data[1], relu_ref(rows[0]));
    end

    // address wrap, then zero length
    clear_log();
    for (int i = 0; i < 3; i++) fq.push_back(rnd_row());
    start_drain(3, 'h7FE, 0);
    wait_idle(10);
    chk("wrap_nwr", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      chk("wrap_a0", wr_addr[0], 11'h7FE);
      chk("wrap_a1", wr_addr[1], 11'h7FF);
      chk("wrap_a2", wr_addr[2], 11'h000);
    end
    clear_log();
    s = cyc;
    start_drain(0, 'h055, 0);
    wait_idle(5);
    chk("zero_nwr", wr_addr.size(), 0);
    chk("zero_done_t", done_cyc, s + 1);
    chk("zero_rows", row_cnt, 12'd0);

    // reset mid-drain
    clear_log();
    for (int i = 0; i < 8; i++) fq.push_back(rnd_row());
    start_drain(8, 'h300, 0);
    n = 0;
    while (wr_addr.size() < 3 && n < 20) begin cycle(); n++; end
    reset = 1'b1;
    cycle();
    chk("rstmid_nwr", wr_addr.size(), 3);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_cen", mem_cen, 1'b1);
    chk("rstmid_addr", mem_addr, 11'h000);
    chk("rstmid_rows", row_cnt, 12'd0);
    reset = 1'b0;
    repeat (2) cycle();
    chk("rstmid_nopop", wr_addr.size(), 3);
    clear_log();
    start_drain(2, 'h040, 0);
    wait_idle(10);
    chk("rst2_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) chk("rst2_a1", wr_addr[1], 11'h041);
    chk("rst2_rows", row_cnt, 12'd2);
    fq.delete();

    // start during drain is ignored
    clear_log();
    for (int i = 0; i < 5; i++) fq.push_back(rnd_row());
    start_drain(5, 'h200, 0);
    cycle();
    len = 12'd1; base_addr = 11'h3F0; start = 1'b1;
    cycle();
    wait_idle(10);
    repeat (3) cycle();
    chk("ign_nwr", wr_addr.size(), 5);
    if (wr_addr.size() == 5) chk("ign_a4", wr_addr[4], 11'h204);
    chk("ign_rows", row_cnt, 12'd5);
    chk("ign_idle", busy, 1'b0);
    fq.delete();

    // randomized drains with random valid/grant, stray starts and rare resets
    for (int it = 0; it < 40; it++) begin
      l = $urandom_range(0, 12);
      n = l + $urandom_range(0, 2);
      for (int i = 0; i < n; i++) fq.push_back(rnd_row());
      v_en = 1; g_en = $urandom_range(0, 1);
      start_drain(l, $urandom_range(0, 2047), $urandom_range(0, 1));
      n = 0;
      while (m_mode != 0 && n < 300) begin
        v_en = ($urandom_range(0, 3) != 0);
        g_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1; len = LW'($urandom); base_addr = AW'($urandom);
        end
        reset = ($urandom_range(0, 79) == 0);
        cycle();
        n++;
      end
      reset = 1'b0;
      if (m_mode != 0) begin
        checks++; errors++;
        $display("FAIL rand_timeout cyc=%0d actual=busy required=idle", cyc);
      end
      cycle();
      fq.delete();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
